// File: rtl/uart_rx.sv
// uart_rx: oversampled 8-bit UART receiver with 3-sample majority vote and optional parity
module uart_rx (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [5:0] Prescale,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic [7:0] P_DATA,
  output logic       data_valid,
  output logic       par_err,
  output logic       stp_err
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t     state;
  logic [5:0] p, cnt, h, ps;
  logic [2:0] bit_cnt, s;
  logic [7:0] sh;
  logic       pen, ptyp, perr, vote, dec, last;
  always_comb begin
    ps   = (Prescale == 6'd16 || Prescale == 6'd32) ? Prescale : 6'd8;
    h    = p >> 1;
    vote = (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    dec  = cnt == h + 6'd2;
    last = cnt == p - 6'd1;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      p          <= 6'd8;
      cnt        <= '0;
      bit_cnt    <= '0;
      s          <= '0;
      sh         <= '0;
      pen        <= 1'b0;
      ptyp       <= 1'b0;
      perr       <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      cnt        <= last ? 6'd0 : cnt + 6'd1;
      if (cnt == h - 6'd1) s[0] <= RX_IN;
      if (cnt == h) s[1] <= RX_IN;
      if (cnt == h + 6'd1) s[2] <= RX_IN;
      case (state)
        IDLE: begin
          cnt <= RX_IN ? 6'd0 : 6'd1;
          if (!RX_IN) begin
            state   <= START;
            p       <= ps;
            pen     <= PAR_EN;
            ptyp    <= PAR_TYP;
            perr    <= 1'b0;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (dec && vote) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (last) state <= DATA;
        end
        DATA: begin
          if (dec) sh <= {vote, sh[7:1]};
          if (last) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= pen ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (dec) perr <= vote != (^sh ^ ptyp);
          if (last) state <= STOP;
        end
        STOP: begin
          // leave mid-bit so the next start edge is seen on its first cycle
          if (dec) begin
            state      <= IDLE;
            cnt        <= '0;
            stp_err    <= !vote;
            par_err    <= pen & perr;
            data_valid <= vote & !(pen & perr);
            if (vote && !(pen && perr)) P_DATA <= sh;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame-level checks of uart_rx against an event-timeline model
module tb_uart_rx;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       data_valid, par_err, stp_err;
  typedef struct packed {int cyc; logic [2:0] f; logic [7:0] d;} ev_t;
  ev_t        got[$], exp_q[$];
  int         cyc = 0;
  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] exp_pd = 8'h00;

  uart_rx dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err),
    .stp_err(stp_err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  // an output registered at edge m belongs to cycle m+1
  always @(negedge CLK)
    if (!RST && (data_valid || par_err || stp_err))
      got.push_back('{cyc + 1, {data_valid, par_err, stp_err}, P_DATA});

  task drive_bit(input logic b, input int n);
    RX_IN = b;
    repeat (n) @(negedge CLK);
  endtask

  task send_frame(input logic [5:0] pd, input logic [7:0] d, input logic pen, input logic ptyp,
                  input logic bad, input logic stop);
    int p, k;
    ev_t e;
    p = (pd == 6'd16 || pd == 6'd32) ? int'(pd) : 8;
    Prescale = pd;
    PAR_EN = pen;
    PAR_TYP = ptyp;
    k = cyc + 1;
    drive_bit(1'b0, p);
    Prescale = 6'($urandom);
    PAR_EN = 1'($urandom);
    PAR_TYP = 1'($urandom);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pen) drive_bit(^d ^ ptyp ^ bad, p);
    Prescale = pd;
    PAR_EN = pen;
    PAR_TYP = ptyp;
    e.f = {1'b0, pen & bad, !stop};
    e.f[2] = e.f[1:0] == 2'b00;
    if (e.f[2]) exp_pd = d;
    e.d = exp_pd;
    e.cyc = k + (pen ? 10 : 9) * p + p / 2 + 3;
    exp_q.push_back(e);
    drive_bit(stop, p);
    if (!stop) drive_bit(1'b1, 2 * p);
  endtask

  task test_reset;
    compared += 4;
    if (P_DATA !== 8'h00) begin mismatched++; $display("FAIL reset P_DATA got %h need 00", P_DATA); end
    if (data_valid !== 1'b0) begin mismatched++; $display("FAIL reset data_valid got %b need 0", data_valid); end
    if (par_err !== 1'b0) begin mismatched++; $display("FAIL reset par_err got %b need 0", par_err); end
    if (stp_err !== 1'b0) begin mismatched++; $display("FAIL reset stp_err got %b need 0", stp_err); end
  endtask

  task test_basic;
    got.delete();
    exp_q.delete();
    send_frame(6'd8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(6'd8, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(6'd8, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(6'd16, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(6'd16, 8'h6E, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(6'd20, 8'hC7, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_bit(1'b1, 8);
    compared++;
    if (got.size() !== exp_q.size()) begin
      mismatched++;
      $display("FAIL basic count got %0d need %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      compared++;
      if (got[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL basic ev%0d got cyc=%0d f=%b d=%h need cyc=%0d f=%b d=%h", i,
                 got[i].cyc, got[i].f, got[i].d, exp_q[i].cyc, exp_q[i].f, exp_q[i].d);
      end
    end
  endtask

  task test_glitch;
    got.delete();
    exp_q.delete();
    Prescale = 6'd8;
    PAR_EN = 1'b0;
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 5);
    send_frame(6'd8, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, 8);
    compared++;
    if (got.size() !== exp_q.size()) begin
      mismatched++;
      $display("FAIL glitch count got %0d need %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      compared++;
      if (got[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL glitch ev%0d got cyc=%0d f=%b d=%h need cyc=%0d f=%b d=%h", i,
                 got[i].cyc, got[i].f, got[i].d, exp_q[i].cyc, exp_q[i].f, exp_q[i].d);
      end
    end
  endtask

  task test_back_to_back;
    got.delete();
    exp_q.delete();
    send_frame(6'd32, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(6'd32, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(6'd32, 8'h96, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_bit(1'b1, 8);
    compared++;
    if (got.size() !== 3) begin
      mismatched++;
      $display("FAIL b2b count got %0d need 3", got.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      compared++;
      if (got[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL b2b ev%0d got cyc=%0d f=%b d=%h need cyc=%0d f=%b d=%h", i,
                 got[i].cyc, got[i].f, got[i].d, exp_q[i].cyc, exp_q[i].f, exp_q[i].d);
      end
      if (i > 0 && i < got.size()) begin
        compared++;
        if (got[i].cyc - got[i-1].cyc !== 352) begin
          mismatched++;
          $display("FAIL b2b spacing%0d got %0d need 352", i, got[i].cyc - got[i-1].cyc);
        end
      end
    end
  endtask

  task test_reset_mid;
    logic [7:0] d;
    got.delete();
    exp_q.delete();
    d = 8'($urandom);
    Prescale = 6'd8;
    PAR_EN = 1'b0;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 8);
    drive_bit(d[4], 3);
    RST = 1'b1;
    @(negedge CLK);
    exp_pd = 8'h00;
    compared += 4;
    if (P_DATA !== 8'h00) begin mismatched++; $display("FAIL rstmid P_DATA got %h need 00", P_DATA); end
    if (data_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid data_valid got %b need 0", data_valid); end
    if (par_err !== 1'b0) begin mismatched++; $display("FAIL rstmid par_err got %b need 0", par_err); end
    if (stp_err !== 1'b0) begin mismatched++; $display("FAIL rstmid stp_err got %b need 0", stp_err); end
    RST = 1'b0;
    drive_bit(1'b1, 64);
    send_frame(6'd8, 8'h42, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, 8);
    compared++;
    if (got.size() !== exp_q.size()) begin
      mismatched++;
      $display("FAIL rstmid count got %0d need %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      compared++;
      if (got[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL rstmid ev%0d got cyc=%0d f=%b d=%h need cyc=%0d f=%b d=%h", i,
                 got[i].cyc, got[i].f, got[i].d, exp_q[i].cyc, exp_q[i].f, exp_q[i].d);
      end
    end
  endtask

  task test_random;
    logic [5:0] pd;
    got.delete();
    exp_q.delete();
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0: pd = 6'd8;
        1: pd = 6'd16;
        2: pd = 6'd32;
        default: begin
          pd = 6'($urandom);
          if (pd == 6'd16 || pd == 6'd32) pd = 6'd5;
        end
      endcase
      send_frame(pd, 8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) != 0);
      drive_bit(1'b1, $urandom_range(0, 3));
    end
    drive_bit(1'b1, 8);
    compared++;
    if (got.size() !== exp_q.size()) begin
      mismatched++;
      $display("FAIL random count got %0d need %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      compared++;
      if (got[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL random ev%0d got cyc=%0d f=%b d=%h need cyc=%0d f=%b d=%h", i,
                 got[i].cyc, got[i].f, got[i].d, exp_q[i].cyc, exp_q[i].f, exp_q[i].d);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    test_reset;
    RST = 1'b0;
    drive_bit(1'b1, 4);
    test_basic;
    test_glitch;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Receive-side UART stage: recovers 8-bit frames from the serial line driven by the team's UART transmitter. Frame format: one start bit (0), 8 data bits LSB first, optional parity bit, one stop bit (1). RX_IN is oversampled at Prescale clocks per bit, and each bit is decided by a 3-sample majority vote. Each accepted frame is delivered as a one-cycle `data_valid` pulse with `P_DATA`; parity and stop failures are flagged instead.

## Interface
- No parameters. Data width is fixed at 8.
- CLK  in  1  single clock; all logic on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- RX_IN  in  1  serial line, idle high, synchronous to CLK (synchronizer lives outside this block).
- Prescale  in  6  clocks per bit; legal values 8, 16 and 32. Any other value is treated as 8.
- PAR_EN  in  1  1 = parity bit present between data and stop.
- PAR_TYP  in  1  0 = even, 1 = odd.
- P_DATA  out  8  last good frame; updated only when `data_valid` asserts, held otherwise.
- data_valid  out  1  one-cycle pulse per good frame.
- par_err  out  1  one-cycle pulse; parity mismatch.
- stp_err  out  1  one-cycle pulse; stop bit sampled 0.

## Operation
- Capture of frame settings:
  - Prescale, PAR_EN and PAR_TYP are captured on start detection and held for the whole frame.
  - Changes mid-frame are ignored.
- Counters:
  - edge_cnt counts 0..P-1 within a bit and wraps at P-1.
  - bit_cnt counts 0..7 in DATA.
- Sampling:
  - RX_IN is sampled at edge_cnt = P/2-1, P/2 and P/2+1.
  - The majority of the three samples is the bit value, available at the decision edge edge_cnt = P/2+2.
- State machine, IDLE → START → DATA → [PARITY] → STOP → IDLE:
  - IDLE: RX_IN sampled 0 → START, with that cycle as edge_cnt 0.
  - START: at the decision edge, if the bit is 1 (glitch), go to IDLE immediately with no outputs. Otherwise continue; at edge P-1 go to DATA.
  - DATA: each decided bit shifts in LSB first. At edge P-1 of bit 7, go to PARITY if PAR_EN, else STOP.
  - PARITY:
    - Expected bit = ^data for even, ~^data for odd.
    - Mismatch latches an internal error.
    - At edge P-1, go to STOP.
  - STOP: at the decision edge, evaluate the stop bit and return to IDLE in the same cycle. The remainder of the stop bit is idle-high, so a following start edge is caught on time.
- Frame end (registered; outputs appear the cycle after the STOP decision edge):
  - stp_err = (stop bit == 0).
  - par_err = parity mismatch, only when PAR_EN.
  - data_valid = !par_err && !stp_err. P_DATA loads the shift register only on data_valid.
  - Both errors may pulse together.
- Reset:
  - All outputs go to 0 (P_DATA = 8'h00), state to IDLE, counters to 0.
  - Reset mid-frame abandons the frame with no pulse.

## Timing
- Let k = the cycle RX_IN is first sampled 0 in IDLE.
- Let n = index of the stop bit (start bit = index 0): n = 9 without parity, 10 with parity.
- The output pulse occurs in cycle k + n·P + P/2 + 3, lasting exactly one cycle.
- Examples:
  - P = 8, no parity: k+79.
  - P = 8, parity: k+87.
  - P = 16, parity: k+171.
- Earliest next start detection: the cycle after the STOP decision edge.
- A start glitch aborts at k + P/2 + 2; the block is back in IDLE the next cycle.
- Outputs are 0 in every cycle other than the frame-end pulse, except P_DATA, which holds.

## Test plan
- Basic frame: P=8, PAR_EN=0, send 0xA5 → data_valid=1 only at k+79, P_DATA=8'hA5, par_err=stp_err=0.
- Even parity: P=8, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 → data_valid at k+87, P_DATA=8'h3C. Repeat with parity 1 → par_err pulse, data_valid=0, P_DATA still 8'h3C.
- Stop error: P=16, PAR_EN=0, send 0x81 with stop=0 → stp_err pulse at k+155, data_valid=0, P_DATA unchanged.
- Start glitch: P=8, RX_IN low for 3 cycles → no pulses, back in IDLE by k+7. A following valid frame of 0x5A is received correctly.
- Back-to-back: P=32, PAR_EN=1, PAR_TYP=1, frames 0x00, 0xFF, 0x96 with no idle gap → three data_valid pulses, each frame_len·32 cycles apart, data in order.
- Reset mid-frame: assert RST during DATA bit 4 → all outputs 0 next cycle, no pulse. The next full frame (0x42) is received normally.
